aes_axis_master_tx: RTL and testbench

- Read side of the AES output FIFO. Pops 128-bit result blocks written by the AES controller.
- Serialises each block into four 32-bit AXI-Stream master beats.
- Asserts tlast on the final beat of the final block of a job. Pulses stream_done once the job is fully transmitted.
- Sits between the output FIFO and the DMA S2MM port; job length comes from the slave-side packet counter.

---
 rtl/aes_axis_master_tx_pkg.sv | 18 +
 rtl/aes_axis_master_tx_if.sv | 10 +
 rtl/aes_axis_master_tx_blk_serializer.sv | 43 ++++
 rtl/aes_axis_master_tx.sv | 75 +++++++
 tb/tb_aes_axis_master_tx.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_axis_master_tx_pkg.sv
// Shared constants, state encoding and helpers for the AES output-FIFO-to-AXIS transmitter.
package aes_axis_master_tx_pkg;
    localparam int BLK_S         = 128;
    localparam int AXIS_W        = 32;
    localparam int WORDS_PER_BLK = 4;
    localparam int WIDX_W        = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } tx_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/aes_axis_master_tx_if.sv
// AXI-Stream bus bundle between the AES transmitter and the DMA S2MM port.
interface aes_axis_master_tx_if #(parameter int W = 32);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/aes_axis_master_tx_blk_serializer.sv
// Holds one 128-bit result block and presents it MSW-first, one 32-bit word per advance.
// AES_AXIS_TX_BSWAP_EN byte-reverses each word for little-endian hosts.
module aes_axis_master_tx_blk_serializer
    import aes_axis_master_tx_pkg::*;
#(
    parameter int W  = AXIS_W,
    parameter int BW = BLK_S
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [BW-1:0] i_blk,
    input  logic          i_adv,
    output logic [W-1:0]  o_word,
    output logic          o_last_word
);
    logic [BW-1:0]     r_shreg;
    logic [WIDX_W-1:0] r_idx;
    logic [W-1:0]      w_slice;

    // Shifting left keeps the current beat at the top, so no wide mux is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg <= '0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_shreg <= i_blk;
            r_idx   <= '0;
        end else if (i_adv) begin
            r_shreg <= r_shreg << W;
            r_idx   <= r_idx + 1'b1;
        end
    end

    assign w_slice     = r_shreg[BW-1 -: W];
    assign o_last_word = (r_idx == WIDX_W'(WORDS_PER_BLK - 1));

`ifdef AES_AXIS_TX_BSWAP_EN
    assign o_word = bswap32(w_slice);
`else
    assign o_word = w_slice;
`endif
endmodule

// File: rtl/aes_axis_master_tx.sv
// Pops 128-bit AES result blocks from the output FIFO and streams them as 4 AXIS beats each.
// Optional build macro: AES_AXIS_TX_BSWAP_EN (byte-reverse every beat).
module aes_axis_master_tx
    import aes_axis_master_tx_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = AXIS_W,
    parameter int OUT_FIFO_DATA_WIDTH  = BLK_S,
    parameter int BLK_CNT_WIDTH        = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           job_start,
    input  logic [BLK_CNT_WIDTH-1:0]       job_blocks,
    input  logic                           out_fifo_read_tvalid,
    output logic                           out_fifo_read_tready,
    input  logic [OUT_FIFO_DATA_WIDTH-1:0] out_fifo_data,
    aes_axis_master_tx_if.master           m_axis,
    output logic                           stream_done,
    output logic                           busy
);
    tx_state_t                         r_state, w_next;
    logic [BLK_CNT_WIDTH-1:0]          r_remaining;
    logic                              w_pop, w_beat, w_last_word;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   w_word;

    assign w_pop  = (r_state == S_FETCH) && out_fifo_read_tvalid;
    assign w_beat = (r_state == S_SEND) && m_axis.tready;

    aes_axis_master_tx_blk_serializer #(
        .W  (C_M_AXIS_TDATA_WIDTH),
        .BW (OUT_FIFO_DATA_WIDTH)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_pop),
        .i_blk       (out_fifo_data),
        .i_adv       (w_beat),
        .o_word      (w_word),
        .o_last_word (w_last_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && job_start)
                r_remaining <= job_blocks;
            else if (w_beat && w_last_word)
                r_remaining <= r_remaining - 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (job_start) w_next = (job_blocks != '0) ? S_FETCH : S_DONE;
            S_FETCH: if (w_pop) w_next = S_SEND;
            // remaining==1 here means the decrement on this beat reaches zero
            S_SEND:  if (w_beat && w_last_word)
                         w_next = (r_remaining == BLK_CNT_WIDTH'(1)) ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign out_fifo_read_tready = (r_state == S_FETCH);
    assign m_axis.tvalid        = (r_state == S_SEND);
    assign m_axis.tdata         = (r_state == S_SEND) ? w_word : '0;
    assign m_axis.tlast         = (r_state == S_SEND) && w_last_word &&
                                  (r_remaining == BLK_CNT_WIDTH'(1));
    assign stream_done          = (r_state == S_DONE);
    assign busy                 = (r_state != S_IDLE);
endmodule

// File: tb/tb_aes_axis_master_tx.sv
// Directed, table-driven bench for aes_axis_master_tx with a small FIFO model and beat monitor.
module tb_aes_axis_master_tx;
    typedef struct packed {
        int                nblk;
        int                rdy_mode;
        int                gap;
        int                poke;
        int                exp_span;
        logic [2:0][127:0] blk;
        logic [11:0][31:0] exp_w;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         job_start;
    logic [15:0]  job_blocks;
    logic         out_fifo_read_tvalid;
    logic         out_fifo_read_tready;
    logic [127:0] out_fifo_data;
    logic         stream_done;
    logic         busy;

    aes_axis_master_tx_if #(.W(32)) m_axis();

    aes_axis_master_tx dut (
        .clk                  (clk),
        .reset                (reset),
        .job_start            (job_start),
        .job_blocks           (job_blocks),
        .out_fifo_read_tvalid (out_fifo_read_tvalid),
        .out_fifo_read_tready (out_fifo_read_tready),
        .out_fifo_data        (out_fifo_data),
        .m_axis               (m_axis),
        .stream_done          (stream_done),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    // FIFO model
    logic [127:0] fmem [0:15];
    int           wp = 0;
    int           rp = 0;
    logic         fflush = 1'b0;
    assign out_fifo_read_tvalid = (wp != rp);
    assign out_fifo_data        = fmem[rp[3:0]];
    always @(posedge clk) begin
        if (fflush) rp <= wp;
        else if (out_fifo_read_tvalid && out_fifo_read_tready) rp <= rp + 1;
    end

    logic rdy_rand = 1'b0;
    always @(posedge clk) begin
        #1;
        m_axis.tready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Monitor, sampled on the falling edge
    int          cyc = 0;
    logic        mon_clr = 1'b0;
    int          beats, pops, last_cnt, last_idx, done_cnt, stall_err;
    int          first_pop_cyc, last_beat_cyc, done_cyc, start_cyc;
    logic [31:0] got_w [16];
    logic        prev_stall;
    logic [31:0] prev_d;
    logic        prev_l;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_clr) begin
            beats <= 0; pops <= 0; last_cnt <= 0; last_idx <= -1; done_cnt <= 0;
            stall_err <= 0; first_pop_cyc <= -1; last_beat_cyc <= -1; done_cyc <= -1;
            start_cyc <= -1; prev_stall <= 1'b0;
        end else begin
            if (job_start && !busy) start_cyc <= cyc;
            if (out_fifo_read_tvalid && out_fifo_read_tready) begin
                if (pops == 0) first_pop_cyc <= cyc;
                pops <= pops + 1;
            end
            if (prev_stall && (!m_axis.tvalid || m_axis.tdata !== prev_d || m_axis.tlast !== prev_l))
                stall_err <= stall_err + 1;
            prev_stall <= m_axis.tvalid && !m_axis.tready;
            prev_d     <= m_axis.tdata;
            prev_l     <= m_axis.tlast;
            if (m_axis.tvalid && m_axis.tready) begin
                if (beats < 16) got_w[beats] <= m_axis.tdata;
                if (m_axis.tlast) begin
                    last_cnt <= last_cnt + 1;
                    last_idx <= beats;
                end
                last_beat_cyc <= cyc;
                beats <= beats + 1;
            end
            if (stream_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] xw(input logic [31:0] w);
`ifdef AES_AXIS_TX_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic push(input logic [127:0] b);
        fmem[wp[3:0]] = b;
        wp++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_env;
        tick;
        fflush = 1'b1; mon_clr = 1'b1; job_start = 1'b0;
        tick;
        fflush = 1'b0; mon_clr = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        clear_env();
        rdy_rand = (v.rdy_mode != 0);
        for (int i = 0; i < v.nblk; i++)
            if (v.gap == 0 || i == 0) push(v.blk[2-i]);
        job_blocks = 16'(v.nblk);
        job_start  = 1'b1;
        tick;
        job_start  = 1'b0;
        for (int c = 0; c < 400 && done_cnt == 0; c++) begin
            if (v.gap != 0 && c == v.gap) begin
                chk({tag, "_gap_tvalid"}, 64'(m_axis.tvalid), 64'd0);
                chk({tag, "_gap_beats"}, 64'(beats), 64'd4);
                for (int i = 1; i < v.nblk; i++) push(v.blk[2-i]);
            end
            if (v.poke != 0 && c == 3) begin job_start = 1'b1; job_blocks = 16'd5; end
            if (v.poke != 0 && c == 4) job_start = 1'b0;
            tick;
        end
        tick; tick;
        rdy_rand = 1'b0;
        chk({tag, "_beats"}, 64'(beats), 64'(4 * v.nblk));
        for (int i = 0; i < 4 * v.nblk && i < 12; i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(got_w[i]), 64'(xw(v.exp_w[11-i])));
        chk({tag, "_tlast_cnt"}, 64'(last_cnt), 64'((v.nblk != 0) ? 1 : 0));
        if (v.nblk != 0) begin
            chk({tag, "_tlast_pos"}, 64'(last_idx), 64'(4 * v.nblk - 1));
            chk({tag, "_done_lat"}, 64'(done_cyc - last_beat_cyc), 64'd1);
        end else begin
            chk({tag, "_done_lat"}, 64'((done_cyc - start_cyc) <= 2), 64'd1);
        end
        chk({tag, "_pops"}, 64'(pops), 64'(v.nblk));
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        if (v.exp_span != 0)
            chk({tag, "_span"}, 64'(last_beat_cyc - first_pop_cyc + 1), 64'(v.exp_span));
        chk({tag, "_stall_stable"}, 64'(stall_err), 64'd0);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 64'(m_axis.tvalid), 64'd0);
        chk({tag, "_tlast"}, 64'(m_axis.tlast), 64'd0);
        chk({tag, "_tdata"}, 64'(m_axis.tdata), 64'd0);
        chk({tag, "_fifo_rdy"}, 64'(out_fifo_read_tready), 64'd0);
        chk({tag, "_done"}, 64'(stream_done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    vec_t  vecs [5];
    string tags [5];

    initial begin
        reset = 1'b1; job_start = 1'b0; job_blocks = '0;
        vecs[0] = '{nblk: 1, rdy_mode: 0, gap: 0, poke: 0, exp_span: 5,
                    blk: {128'h00112233_44556677_8899AABB_CCDDEEFF, 256'h0},
                    exp_w: {32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 256'h0}};
        vecs[1] = '{nblk: 3, rdy_mode: 0, gap: 0, poke: 1, exp_span: 15,
                    blk: {128'h10000001_10000002_10000003_10000004,
                          128'h20000001_20000002_20000003_20000004,
                          128'h30000001_30000002_30000003_30000004},
                    exp_w: {32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004,
                            32'h20000001, 32'h20000002, 32'h20000003, 32'h20000004,
                            32'h30000001, 32'h30000002, 32'h30000003, 32'h30000004}};
        vecs[2] = '{nblk: 2, rdy_mode: 1, gap: 0, poke: 0, exp_span: 0,
                    blk: {128'hDEADBEEF_CAFEBABE_0BADF00D_FEEDFACE,
                          128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978, 128'h0},
                    exp_w: {32'hDEADBEEF, 32'hCAFEBABE, 32'h0BADF00D, 32'hFEEDFACE,
                            32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978, 128'h0}};
        vecs[3] = '{nblk: 2, rdy_mode: 0, gap: 20, poke: 0, exp_span: 0,
                    blk: {128'hA5A5A5A5_5A5A5A5A_FFFF0000_0000FFFF,
                          128'h11111111_22222222_33333333_44444444, 128'h0},
                    exp_w: {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFF0000, 32'h0000FFFF,
                            32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 128'h0}};
        vecs[4] = '{nblk: 0, rdy_mode: 0, gap: 0, poke: 0, exp_span: 0,
                    blk: 384'h0, exp_w: 384'h0};
        tags = '{"one_blk", "three_blk", "rand_rdy", "late_blk", "zero_blk"};

        tick; tick; tick;
        @(negedge clk);
        chk_reset_outputs("por");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int k = 0; k < 5; k++) run_vec(vecs[k], tags[k]);

        // Reset in the middle of the first block of a two-block job
        clear_env();
        push(vecs[2].blk[2]);
        push(vecs[2].blk[1]);
        job_blocks = 16'd2;
        job_start  = 1'b1;
        tick;
        job_start  = 1'b0;
        for (int c = 0; c < 50 && beats < 2; c++) tick;
        chk("midrst_reached", 64'(beats >= 2), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("midrst");
        chk("midrst_no_tlast", 64'(last_cnt), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_vec(vecs[0], "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
